// File: rtl/my_chip.sv
// my_chip: minimal multi-cycle 16-bit core with sixteen general registers.
// It has no program counter. The environment presents each instruction, and
// the immediate word for a load, on INSTRUCTION in step with the FSM.
//
// state | meaning
// ------+---------------------------------------------------------------
// T0    | fetch/decode: latch opcode/rx/ry, branch on opcode
// LD    | load data cycle: R[rx] <= INSTRUCTION, done pulse
// MV    | move: R[rx] <= R[ry], done pulse
// T1    | capture A <= R[rx]
// T2    | capture G <= A op R[ry]
// T3    | write back: R[rx] <= G, done pulse
module my_chip #(
  parameter int REG_WIDTH = 16,
  parameter int NUM_REGS  = 16
) (
  input  logic [REG_WIDTH-1:0] INSTRUCTION,
  input  logic                 clk,
  input  logic                 reset,
  output logic                 done,
  output logic [REG_WIDTH-1:0] bus
);

  typedef enum logic [2:0] {
    S_T0 = 3'd0,
    S_LD = 3'd1,
    S_MV = 3'd2,
    S_T1 = 3'd3,
    S_T2 = 3'd4,
    S_T3 = 3'd5
  } state_t;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_MOV  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;

  state_t                 state;
  state_t                 state_nxt;
  logic [2:0]             opcode;
  logic [3:0]             rx;
  logic [3:0]             ry;
  logic [REG_WIDTH-1:0]   rf [NUM_REGS];
  logic [REG_WIDTH-1:0]   a_reg;
  logic [REG_WIDTH-1:0]   g_reg;
  logic [REG_WIDTH-1:0]   alu_res;

  // The top five instruction bits carry no meaning.
  logic unused_ok;
  assign unused_ok = ^INSTRUCTION[REG_WIDTH-1:11];

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk) begin
    if (reset) state <= S_T0;
    else       state <= state_nxt;
  end

  // Next-state decode and write-back outputs. done and bus are asserted only
  // in the single write-back cycle of each instruction.
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    bus       = '0;
    case (state)
      S_T0: begin
        case (INSTRUCTION[10:8])
          OP_LOAD:                state_nxt = S_LD;
          OP_MOV:                 state_nxt = S_MV;
          OP_ADD, OP_SUB, OP_XOR: state_nxt = S_T1;
          default:                state_nxt = S_T0;
        endcase
      end
      S_LD: begin
        done      = 1'b1;
        bus       = INSTRUCTION;
        state_nxt = S_T0;
      end
      S_MV: begin
        done      = 1'b1;
        bus       = rf[ry];
        state_nxt = S_T0;
      end
      S_T1: state_nxt = S_T2;
      S_T2: state_nxt = S_T3;
      S_T3: begin
        done      = 1'b1;
        bus       = g_reg;
        state_nxt = S_T0;
      end
      default: state_nxt = S_T0;
    endcase
  end

  // ALU; operands come from A (old rx value) and R[ry], so rx == ry works.
  always_comb begin
    alu_res = a_reg;
    case (opcode)
      OP_ADD:  alu_res = a_reg + rf[ry];
      OP_SUB:  alu_res = a_reg - rf[ry];
      OP_XOR:  alu_res = a_reg ^ rf[ry];
      default: alu_res = a_reg;
    endcase
  end

  // Datapath: instruction latch, A/G capture and register-file write-back.
  always_ff @(posedge clk) begin
    if (reset) begin
      opcode <= '0;
      rx     <= '0;
      ry     <= '0;
      a_reg  <= '0;
      g_reg  <= '0;
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else begin
      if (state == S_T0) begin
        opcode <= INSTRUCTION[10:8];
        rx     <= INSTRUCTION[7:4];
        ry     <= INSTRUCTION[3:0];
      end
      if (state == S_T1) a_reg <= rf[rx];
      if (state == S_T2) g_reg <= alu_res;
      if (done)          rf[rx] <= bus;
    end
  end

endmodule

// File: tb/tb_my_chip.sv
// Directed bench for my_chip. Register contents are observed through the
// ports by issuing "mov rn,rn", which reports R[n] on bus without changing it.
module tb_my_chip;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instruction;
  logic        done;
  logic [15:0] bus;

  int checks   = 0;
  int failures = 0;

  localparam logic [15:0] NOP = 16'h0700;

  my_chip dut (
    .INSTRUCTION(instruction),
    .clk        (clk),
    .reset      (reset),
    .done       (done),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive ins after the falling edge, check outputs before
  // the next rising edge.
  task automatic cyc(input logic [15:0] ins, input logic exp_done,
                     input logic [15:0] exp_bus, input string tag);
    @(negedge clk);
    instruction = ins;
    #1;
    check_val({tag, ".done"}, {15'b0, done}, {15'b0, exp_done});
    check_val({tag, ".bus"}, bus, exp_bus);
  endtask

  task automatic do_load(input logic [3:0] r, input logic [15:0] val, input string tag);
    cyc({8'h00, r, 4'h0}, 1'b0, 16'h0000, {tag, ".t0"});
    cyc(val, 1'b1, val, {tag, ".ld"});
  endtask

  task automatic do_mov(input logic [3:0] r_x, input logic [3:0] r_y,
                        input logic [15:0] exp, input string tag);
    cyc({8'h01, r_x, r_y}, 1'b0, 16'h0000, {tag, ".t0"});
    cyc(NOP, 1'b1, exp, {tag, ".mv"});
  endtask

  task automatic peek(input logic [3:0] r, input logic [15:0] exp, input string tag);
    do_mov(r, r, exp, tag);
  endtask

  task automatic do_alu(input logic [2:0] op, input logic [3:0] r_x, input logic [3:0] r_y,
                        input logic [15:0] exp, input string tag);
    cyc({5'b0, op, r_x, r_y}, 1'b0, 16'h0000, {tag, ".t0"});
    cyc(NOP, 1'b0, 16'h0000, {tag, ".t1"});
    cyc(NOP, 1'b0, 16'h0000, {tag, ".t2"});
    cyc(NOP, 1'b1, exp, {tag, ".t3"});
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset       = 1'b1;
    instruction = NOP;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_val("reset.done", {15'b0, done}, 16'h0000);
    check_val("reset.bus", bus, 16'h0000);
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    instruction = NOP;
    apply_reset();

    // Loads and moves.
    do_load(4'd1, 16'h0007, "ld_r1");
    do_load(4'd2, 16'h0008, "ld_r2");
    do_mov(4'd3, 4'd2, 16'h0008, "mov_r3_r2");
    peek(4'd2, 16'h0008, "peek_r2");
    peek(4'd1, 16'h0007, "peek_r1");

    // ALU operations.
    do_alu(3'b010, 4'd3, 4'd1, 16'h000F, "add_r3_r1");
    do_alu(3'b011, 4'd1, 4'd2, 16'hFFFF, "sub_r1_r2");
    do_mov(4'd4, 4'd1, 16'hFFFF, "mov_r4_r1");
    do_alu(3'b100, 4'd1, 4'd2, 16'hFFF7, "xor_r1_r2");
    peek(4'd4, 16'hFFFF, "peek_r4");
    peek(4'd3, 16'h000F, "peek_r3");
    peek(4'd2, 16'h0008, "peek_r2b");

    do_load(4'd8, 16'h1234, "ld_r8");
    do_load(4'd9, 16'h0F0F, "ld_r9");
    do_alu(3'b100, 4'd8, 4'd9, 16'h1D3B, "xor_r8_r9");
    do_alu(3'b010, 4'd8, 4'd9, 16'h2C4A, "add_r8_r9");
    peek(4'd9, 16'h0F0F, "peek_r9");

    // Wrap and aliasing.
    do_load(4'd5, 16'h8000, "ld_r5");
    do_alu(3'b010, 4'd5, 4'd5, 16'h0000, "add_r5_r5");
    peek(4'd5, 16'h0000, "peek_r5");
    do_load(4'd6, 16'h4321, "ld_r6");
    do_alu(3'b010, 4'd6, 4'd6, 16'h8642, "dbl_r6");
    do_alu(3'b011, 4'd6, 4'd6, 16'h0000, "sub_r6_r6");
    do_load(4'd7, 16'hA5A5, "ld_r7");
    do_alu(3'b100, 4'd7, 4'd7, 16'h0000, "xor_r7_r7");

    // r0 is a real register.
    do_load(4'd0, 16'hABCD, "ld_r0");
    peek(4'd0, 16'hABCD, "peek_r0");

    // No-op opcodes take one cycle and change nothing.
    cyc(16'h0731, 1'b0, 16'h0000, "nop111");
    peek(4'd3, 16'h000F, "after_nop111");
    cyc(16'h0513, 1'b0, 16'h0000, "nop101");
    cyc(16'h0613, 1'b0, 16'h0000, "nop110");
    peek(4'd1, 16'hFFF7, "after_nop110");

    // Bits [15:11] are ignored: 0xF933 decodes as mov r3,r3.
    cyc(16'hF933, 1'b0, 16'h0000, "hibits.t0");
    cyc(NOP, 1'b1, 16'h000F, "hibits.mv");

    // Reset during T2 of add r3,r1 aborts it and clears the registers.
    cyc(16'h0231, 1'b0, 16'h0000, "abort.t0");
    cyc(NOP, 1'b0, 16'h0000, "abort.t1");
    @(negedge clk);
    reset       = 1'b1;
    instruction = NOP;
    #1;
    check_val("abort.t2.done", {15'b0, done}, 16'h0000);
    @(negedge clk);
    #1;
    check_val("abort.rst.done", {15'b0, done}, 16'h0000);
    check_val("abort.rst.bus", bus, 16'h0000);
    reset = 1'b0;
    cyc(NOP, 1'b0, 16'h0000, "abort.idle");
    peek(4'd3, 16'h0000, "abort.r3");
    peek(4'd1, 16'h0000, "abort.r1");
    peek(4'd0, 16'h0000, "abort.r0");
    do_load(4'd6, 16'h1234, "post_rst_ld");
    peek(4'd6, 16'h1234, "post_rst_peek");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
